// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter for the shared 4-input, 32-bit select multiplexer.
//   One requester holds the mux at a time. A grant lasts until the holder
//   marks its last beat, drops its request, or reaches MAX_HOLD beats. At that
//   point the arbiter hands the mux to the next requester in round-robin order
//   on the same edge, with no idle cycle in between.
//
//   Handshake: the mux carries valid data only while valid_o is high.
//   grant_o/select_o name the holder for that cycle. req_i[k] is a level
//   request and is not latched, so a requester must keep its bit high until it
//   is granted. last_i is sampled only while a grant is active.
//
// Ports
//   clk_i      clock; all state changes on the rising edge
//   rst_i      asynchronous, active-low reset
//   req_i      per-requester request, bit k = requester k
//   last_i     holder's final-beat marker
//   grant_o    registered one-hot grant, all zero when idle
//   select_o   mux select = index of the granted requester (held when idle)
//   valid_o    grant active
//   preempt_o  one-cycle pulse after a grant is ended by MAX_HOLD
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    input  logic       last_i,
    output logic [3:0] grant_o,
    output logic [1:0] select_o,
    output logic       valid_o,
    output logic       preempt_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0] state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       preempt_q, preempt_d;

    // Release conditions for the current holder
    logic rel_last, rel_drop, rel_hold, release_now;
    logic [1:0] next_ptr;
    logic [2:0] pick_idle, pick_rel;

    // Returns {found, index}. The scan starts at ptr and wraps, so the first
    // set bit at or after ptr wins. Iterating from the farthest offset down
    // to offset 0 lets the nearest hit overwrite the result last.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign rel_last    = last_i;
    assign rel_drop    = ~req_i[sel_q];
    assign rel_hold    = (cnt_q == HOLD_LAST);
    assign release_now = rel_last | rel_drop | rel_hold;
    assign next_ptr    = sel_q + 2'd1;
    assign pick_idle   = rr_pick(req_i, ptr_q);
    assign pick_rel    = rr_pick(req_i, next_ptr);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_idle[2]) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idle[1:0];
                    grant_d = 4'b0001 << pick_idle[1:0];
                    cnt_d   = 8'd0;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    // The holder moves to lowest priority before re-arbitrating.
                    ptr_d     = next_ptr;
                    preempt_d = rel_hold & ~rel_last & ~rel_drop;
                    cnt_d     = 8'd0;
                    if (pick_rel[2]) begin
                        sel_d   = pick_rel[1:0];
                        grant_d = 4'b0001 << pick_rel[1:0];
                    end else begin
                        // Going idle: select_o keeps pointing at the last holder.
                        state_d = ST_IDLE;
                        grant_d = 4'b0000;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= 4'b0000;
            sel_q     <= 2'd0;
            ptr_q     <= 2'd0;
            cnt_q     <= 8'd0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant_o   = grant_q;
    assign select_o  = sel_q;
    assign valid_o   = (state_q == ST_GRANT);
    assign preempt_o = preempt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (MAX_HOLD = 16).
module tb_mux_rr_arbiter;

    logic       clk_i;
    logic       rst_i;
    logic [3:0] req_i;
    logic       last_i;
    logic [3:0] grant_o;
    logic [1:0] select_o;
    logic       valid_o;
    logic       preempt_o;

    int n_assert;
    int n_fail;

    mux_rr_arbiter #(.MAX_HOLD(16)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .last_i    (last_i),
        .grant_o   (grant_o),
        .select_o  (select_o),
        .valid_o   (valid_o),
        .preempt_o (preempt_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full output check in one call.
    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic v, input logic p);
        chk({tag, ".grant"},   32'(grant_o),   32'(g));
        chk({tag, ".select"},  32'(select_o),  32'(s));
        chk({tag, ".valid"},   32'(valid_o),   32'(v));
        chk({tag, ".preempt"}, 32'(preempt_o), 32'(p));
    endtask

    logic [3:0] rr_exp [8];

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_i    = 1'b0;
        req_i    = 4'b0000;
        last_i   = 1'b0;
        rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                     4'b0001, 4'b0010, 4'b0100, 4'b1000};

        // reset state
        #12;
        chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();
        chk_all("idle_after_reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // single requester 2: three granted beats, last on the third
        req_i = 4'b0100;
        tick();
        chk_all("single.b0", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        chk_all("single.b1", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        chk_all("single.b2", 4'b0100, 2'd2, 1'b1, 1'b0);
        last_i = 1'b1;
        req_i  = 4'b0000;
        tick();
        chk_all("single.idle", 4'b0000, 2'd2, 1'b0, 1'b0);
        last_i = 1'b0;
        tick();
        chk_all("single.stay_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

        // asynchronous reset during an active grant
        req_i = 4'b0001;
        tick();
        chk_all("pre_reset_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        #2;
        rst_i = 1'b0;
        #1;
        chk_all("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        req_i = 4'b0000;
        @(negedge clk_i);
        rst_i = 1'b1;

        // round-robin fairness: all request, last every beat
        req_i  = 4'b1111;
        last_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rr.grant%0d", i), 32'(grant_o), 32'(rr_exp[i]));
            chk($sformatf("rr.valid%0d", i), 32'(valid_o), 32'd1);
        end
        // holder 3 releases with nobody requesting -> idle, pointer now 0
        req_i  = 4'b0000;
        last_i = 1'b0;
        tick();
        chk_all("rr.idle", 4'b0000, 2'd3, 1'b0, 1'b0);

        // preemption: requester 0 held exactly 16 beats
        req_i = 4'b0011;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_all($sformatf("hold.b%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        tick();
        chk_all("preempt.pulse", 4'b0010, 2'd1, 1'b1, 1'b1);
        tick();
        chk_all("preempt.done", 4'b0010, 2'd1, 1'b1, 1'b0);

        // hand over from 1 to 2 via last
        req_i  = 4'b0110;
        last_i = 1'b1;
        tick();
        chk_all("to2", 4'b0100, 2'd2, 1'b1, 1'b0);
        last_i = 1'b0;
        tick();
        chk_all("hold2", 4'b0100, 2'd2, 1'b1, 1'b0);

        // holder 2 drops; scan 3,0,1 picks 1
        req_i = 4'b0010;
        tick();
        chk_all("drop2_to1", 4'b0010, 2'd1, 1'b1, 1'b0);

        // holder 1 drops while 3 requests
        req_i = 4'b1000;
        tick();
        chk_all("to3", 4'b1000, 2'd3, 1'b1, 1'b0);

        // sole requester 3 preempted, re-granted immediately
        for (int i = 1; i < 16; i++) begin
            tick();
            chk_all($sformatf("sole.b%0d", i), 4'b1000, 2'd3, 1'b1, 1'b0);
        end
        tick();
        chk_all("sole.regrant", 4'b1000, 2'd3, 1'b1, 1'b1);
        tick();
        chk_all("sole.after", 4'b1000, 2'd3, 1'b1, 1'b0);

        // drop to idle
        req_i = 4'b0000;
        tick();
        chk_all("final.idle", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick();
        chk_all("final.stay_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
